fnd_timer_display: RTL and testbench

//  Downstream display stage of the microwave controller: converts remaining-seconds count to MM:SS
//  and drives a 4-digit common-anode 7-segment (FND) by time-multiplexed scanning.

---
 rtl/fnd_timer_display.sv | 207 ++++++++++++++++++++
 tb/tb_fnd_timer_display.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/fnd_timer_display.sv
// MM:SS timer display for a 4-digit common-anode FND: converts a seconds count with a
// subtract-only FSM and scans the digits, with a blinking colon and a FINISH flash.
module fnd_timer_display #(
    parameter int unsigned SEC_W     = 11,
    parameter int unsigned SCAN_DIV  = 100_000,
    parameter int unsigned BLINK_DIV = 50_000_000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [SEC_W-1:0] i_sec,
    input  logic             i_run,
    input  logic [3:0]       i_state,
    output logic [3:0]       o_fnd_com,
    output logic [7:0]       o_fnd_data
);

    localparam int unsigned SCAN_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    typedef enum logic [2:0] {StIdle, StDiv60, StDiv10M, StDiv10S, StLoad} conv_st_e;

    conv_st_e           r_conv_st, w_conv_st;
    logic [SEC_W-1:0]   r_cap, w_cap;
    logic [SEC_W-1:0]   r_rem, w_rem;
    logic [SEC_W-1:0]   r_min, w_min;
    logic [3:0]         r_min_t, w_min_t;
    logic [3:0]         r_sec_t, w_sec_t;
    logic               w_load;
    logic [3:0]         r_dig0, r_dig1, r_dig2, r_dig3;
    logic [SCAN_W-1:0]  r_scan_cnt;
    logic [1:0]         r_idx;
    logic [BLINK_W-1:0] r_blink_cnt;
    logic               r_blink_on, r_run_q, r_fin_q;
    logic               w_fin, w_run_mode, w_dp;
    logic [3:0]         w_digit, w_com;
    logic [7:0]         w_data;

    function automatic logic [7:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 8'hC0;
            4'd1:    seg7 = 8'hF9;
            4'd2:    seg7 = 8'hA4;
            4'd3:    seg7 = 8'hB0;
            4'd4:    seg7 = 8'h99;
            4'd5:    seg7 = 8'h92;
            4'd6:    seg7 = 8'h82;
            4'd7:    seg7 = 8'hF8;
            4'd8:    seg7 = 8'h80;
            4'd9:    seg7 = 8'h90;
            default: seg7 = 8'hFF;
        endcase
    endfunction

    // Conversion: one subtract per cycle, digits only published in StLoad.
    always_comb begin
        w_conv_st = r_conv_st;
        w_cap     = r_cap;
        w_rem     = r_rem;
        w_min     = r_min;
        w_min_t   = r_min_t;
        w_sec_t   = r_sec_t;
        w_load    = 1'b0;
        case (r_conv_st)
            StIdle: begin
                if (i_sec != r_cap) begin
                    w_cap     = i_sec;
                    w_rem     = i_sec;
                    w_min     = '0;
                    w_min_t   = '0;
                    w_sec_t   = '0;
                    w_conv_st = StDiv60;
                end
            end
            StDiv60: begin
                if (r_rem >= SEC_W'(60)) begin
                    w_rem = r_rem - SEC_W'(60);
                    w_min = r_min + SEC_W'(1);
                end else begin
                    w_conv_st = StDiv10M;
                end
            end
            StDiv10M: begin
                if (r_min >= SEC_W'(10)) begin
                    w_min   = r_min - SEC_W'(10);
                    w_min_t = r_min_t + 4'd1;
                end else begin
                    w_conv_st = StDiv10S;
                end
            end
            StDiv10S: begin
                if (r_rem >= SEC_W'(10)) begin
                    w_rem   = r_rem - SEC_W'(10);
                    w_sec_t = r_sec_t + 4'd1;
                end else begin
                    w_conv_st = StLoad;
                end
            end
            StLoad: begin
                w_load    = 1'b1;
                w_conv_st = StIdle;
            end
            default: w_conv_st = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_conv_st <= StIdle;
            r_cap     <= '0;
            r_rem     <= '0;
            r_min     <= '0;
            r_min_t   <= '0;
            r_sec_t   <= '0;
            r_dig0    <= '0;
            r_dig1    <= '0;
            r_dig2    <= '0;
            r_dig3    <= '0;
        end else begin
            r_conv_st <= w_conv_st;
            r_cap     <= w_cap;
            r_rem     <= w_rem;
            r_min     <= w_min;
            r_min_t   <= w_min_t;
            r_sec_t   <= w_sec_t;
            if (w_load) begin
                r_dig0 <= r_rem[3:0];
                r_dig1 <= r_sec_t;
                r_dig2 <= r_min[3:0];
                r_dig3 <= r_min_t;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_scan_cnt <= '0;
            r_idx      <= '0;
        end else if (r_scan_cnt == SCAN_W'(SCAN_DIV - 1)) begin
            r_scan_cnt <= '0;
            r_idx      <= r_idx + 2'd1;
        end else begin
            r_scan_cnt <= r_scan_cnt + SCAN_W'(1);
        end
    end

    // Blink phase restarts ON at run start and at FINISH entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_blink_cnt <= '0;
            r_blink_on  <= 1'b1;
            r_run_q     <= 1'b0;
            r_fin_q     <= 1'b0;
        end else begin
            r_run_q <= i_run;
            r_fin_q <= w_fin;
            if ((i_run && !r_run_q) || (w_fin && !r_fin_q)) begin
                r_blink_cnt <= '0;
                r_blink_on  <= 1'b1;
            end else if (r_blink_cnt == BLINK_W'(BLINK_DIV - 1)) begin
                r_blink_cnt <= '0;
                r_blink_on  <= ~r_blink_on;
            end else begin
                r_blink_cnt <= r_blink_cnt + BLINK_W'(1);
            end
        end
    end

    always_comb begin
        w_fin      = 1'b0;
        w_run_mode = 1'b0;
        casez (i_state)
            4'b1???: w_fin      = 1'b1;
            4'b01??: w_run_mode = 1'b1;
            default: ;
        endcase
        w_dp = (w_run_mode && i_run) ? r_blink_on : 1'b1;
        case (r_idx)
            2'd0:    w_digit = r_dig0;
            2'd1:    w_digit = r_dig1;
            2'd2:    w_digit = r_dig2;
            default: w_digit = r_dig3;
        endcase
        w_data = seg7(w_digit);
        if (r_idx == 2'd3 && r_dig3 == 4'd0) begin
            w_data = 8'hFF;
        end
        if (r_idx == 2'd2 && w_dp) begin
            w_data[7] = 1'b0;
        end
        w_com = ~(4'b0001 << r_idx);
        if (w_fin && !r_blink_on) begin
            w_com  = 4'b1111;
            w_data = 8'hFF;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            o_fnd_com  <= 4'b1111;
            o_fnd_data <= 8'hFF;
        end else begin
            o_fnd_com  <= w_com;
            o_fnd_data <= w_data;
        end
    end

endmodule

// File: tb/tb_fnd_timer_display.sv
// Bench for fnd_timer_display: scoreboard of expected digit patterns from an MM:SS model,
// plus cycle-indexed checks of colon blink and FINISH flash.
module tb_fnd_timer_display;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [10:0] i_sec = '0;
    logic        i_run = 1'b0;
    logic [3:0]  i_state = 4'b0001;
    logic [3:0]  o_fnd_com;
    logic [7:0]  o_fnd_data;

    int          n_tests = 0;
    int          n_fail = 0;
    logic [11:0] exp_q[$];
    int          wait_cnt = 0;
    logic [7:0]  seg_tbl[10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

    fnd_timer_display #(
        .SEC_W    (11),
        .SCAN_DIV (4),
        .BLINK_DIV(16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .i_sec     (i_sec),
        .i_run     (i_run),
        .i_state   (i_state),
        .o_fnd_com (o_fnd_com),
        .o_fnd_data(o_fnd_data)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] exp_data(input int sec, input int idx, input bit dp);
        int m = sec / 60;
        int s = sec % 60;
        int d;
        logic [7:0] v;
        case (idx)
            0:       d = s % 10;
            1:       d = s / 10;
            2:       d = m % 10;
            default: d = m / 10;
        endcase
        v = (idx == 3 && d == 0) ? 8'hFF : seg_tbl[d];
        if (idx == 2 && dp) v[7] = 1'b0;
        return v;
    endfunction

    function automatic int com_idx(input logic [3:0] com);
        case (com)
            4'b1110: return 0;
            4'b1101: return 1;
            4'b1011: return 2;
            4'b0111: return 3;
            default: return -1;
        endcase
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic push_display(input int sec, input bit dp);
        logic [3:0] c;
        for (int idx = 0; idx < 4; idx++) begin
            c = 4'b1111;
            c[idx] = 1'b0;
            exp_q.push_back({c, exp_data(sec, idx, dp)});
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 2000 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic set_and_check(input int sec);
        @(negedge clk);
        i_sec = 11'(sec);
        repeat (60) @(negedge clk);
        push_display(sec, 1'b1);
        drain();
    endtask

    // Monitor: pops the next expected digit when its enable shows up on the bus.
    always @(negedge clk) begin
        if (reset || exp_q.size() == 0) begin
            wait_cnt = 0;
        end else if (o_fnd_com == exp_q[0][11:8]) begin
            n_tests++;
            if (o_fnd_data !== exp_q[0][7:0]) begin
                n_fail++;
                $display("FAIL scan com=%b: data %h, expected %h", o_fnd_com, o_fnd_data,
                         exp_q[0][7:0]);
            end
            void'(exp_q.pop_front());
            wait_cnt = 0;
        end else begin
            wait_cnt++;
            if (wait_cnt > 100) begin
                n_tests++;
                n_fail++;
                $display("FAIL scan timeout: com %b never seen, last com %b", exp_q[0][11:8],
                         o_fnd_com);
                void'(exp_q.pop_front());
                wait_cnt = 0;
            end
        end
    end

    initial begin
        int bad;
        int ix;
        bit on;
        repeat (3) @(negedge clk);
        check("reset_com", {4'h0, o_fnd_com}, 8'h0F);
        check("reset_data", o_fnd_data, 8'hFF);
        @(negedge clk);
        reset = 1'b0;
        push_display(0, 1'b1);
        drain();

        i_state = 4'b0010;
        set_and_check(125);
        set_and_check(2047);
        set_and_check(599);
        set_and_check(600);
        for (int n = 0; n < 6; n++) set_and_check(int'($urandom_range(0, 2047)));
        set_and_check(2047);

        // 60 then 59 shortly after capture: only 34:07, 01:00 or 00:59 digits may appear.
        @(negedge clk);
        i_sec = 11'd60;
        repeat (3) @(posedge clk);
        #1 i_sec = 11'd59;
        bad = 0;
        for (int k = 0; k < 120; k++) begin
            @(negedge clk);
            ix = com_idx(o_fnd_com);
            if (ix < 0 || (o_fnd_data != exp_data(2047, ix, 1'b1) &&
                           o_fnd_data != exp_data(60, ix, 1'b1) &&
                           o_fnd_data != exp_data(59, ix, 1'b1))) bad++;
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL transient: %0d unexpected samples, expected 0", bad);
        end
        push_display(59, 1'b1);
        drain();

        // Colon blink in RUN, phase restarted by i_run rising edge.
        @(negedge clk);
        i_state = 4'b0100;
        repeat (5) @(negedge clk);
        i_run = 1'b1;
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            if (k >= 1 && o_fnd_com == 4'b1011) begin
                on = (((k - 1) / 16) % 2) == 0;
                check($sformatf("blink_k%0d", k), o_fnd_data, exp_data(59, 2, on));
            end
        end
        i_state = 4'b0010;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (k >= 1 && o_fnd_com == 4'b1011)
                check($sformatf("setting_dp_k%0d", k), o_fnd_data, exp_data(59, 2, 1'b1));
        end
        i_run = 1'b0;

        // FINISH flash: ON phase first after entry.
        @(negedge clk);
        i_state = 4'b1000;
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            if (k >= 1) begin
                on = (((k - 1) / 16) % 2) == 0;
                if (on) begin
                    ix = com_idx(o_fnd_com);
                    n_tests++;
                    if (ix < 0) begin
                        n_fail++;
                        $display("FAIL finish_on_k%0d: com %b, expected one active digit", k,
                                 o_fnd_com);
                    end else if (o_fnd_data !== exp_data(59, ix, 1'b1)) begin
                        n_fail++;
                        $display("FAIL finish_on_k%0d: data %h, expected %h", k, o_fnd_data,
                                 exp_data(59, ix, 1'b1));
                    end
                end else begin
                    check($sformatf("finish_off_com_k%0d", k), {4'h0, o_fnd_com}, 8'h0F);
                    check($sformatf("finish_off_data_k%0d", k), o_fnd_data, 8'hFF);
                end
            end
        end

        // Asynchronous reset in the middle of a conversion.
        @(negedge clk);
        i_state = 4'b0010;
        i_sec = 11'd2047;
        repeat (6) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("midreset_com", {4'h0, o_fnd_com}, 8'h0F);
        check("midreset_data", o_fnd_data, 8'hFF);
        i_sec = 11'd0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        push_display(0, 1'b1);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
